// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared RV32M funct3, state and iteration constants
package muldiv_pkg;

    localparam int ITER_COUNT = 32;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, fixed 33-cycle latency
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_num,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_rd,
    output logic            result_we
);

    state_t            state, nextState;
    logic [5:0]        stepCnt;
    logic [2:0]        op;
    logic [4:0]        rdReg;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operandB;
    logic              negA, negB, divZero, divOvf;
    logic              aSigned, bSigned;
    logic [XLEN:0]     mulSum, divDiff;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic isSigned);
        return (isSigned && v[XLEN-1]) ? -v : v;
    endfunction

    // acc holds {hi, lo} product for multiplies, {remainder, quotient} for divides.
    function automatic logic [XLEN-1:0] finalize(input logic [2:0] f, input logic [2*XLEN-1:0] a,
                                                 input logic nA, input logic nB,
                                                 input logic dz, input logic ovf);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo, rem;
        prod = (nA ^ nB) ? -a : a;
        quo  = a[XLEN-1:0];
        rem  = a[2*XLEN-1:XLEN];
        case (f)
            FUNCT3_MUL:  return prod[XLEN-1:0];
            FUNCT3_DIV:  return dz ? '1 : ovf ? {1'b1, {(XLEN-1){1'b0}}} : ((nA ^ nB) ? -quo : quo);
            FUNCT3_DIVU: return dz ? '1 : quo;
            FUNCT3_REM:  return ovf ? '0 : (nA ? -rem : rem);
            FUNCT3_REMU: return rem;
            default:     return prod[2*XLEN-1:XLEN];
        endcase
    endfunction

    always_comb begin
        aSigned = (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU) ||
                  (funct3 == FUNCT3_DIV)  || (funct3 == FUNCT3_REM);
        bSigned = (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
        mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operandB : {XLEN{1'b0}})};
        divDiff = acc[2*XLEN-1:XLEN-1] - {1'b0, operandB};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (start) nextState = ST_RUN;
            ST_RUN:  if (stepCnt == 6'(ITER_COUNT)) nextState = ST_DONE;
            ST_DONE: nextState = start ? ST_RUN : ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stepCnt   <= '0;
            op        <= '0;
            rdReg     <= '0;
            acc       <= '0;
            operandB  <= '0;
            negA      <= 1'b0;
            negB      <= 1'b0;
            divZero   <= 1'b0;
            divOvf    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_rd <= '0;
            result_we <= 1'b0;
        end else begin
            busy      <= (nextState == ST_RUN);
            done      <= (nextState == ST_DONE);
            result_we <= (nextState == ST_DONE) && (rdReg != 5'd0);
            if (state != ST_RUN) begin
                if (start) begin
                    op       <= funct3;
                    rdReg    <= rd_num;
                    acc      <= {{XLEN{1'b0}}, magnitude(rs1_data, aSigned)};
                    operandB <= magnitude(rs2_data, bSigned);
                    negA     <= aSigned && rs1_data[XLEN-1];
                    negB     <= bSigned && rs2_data[XLEN-1];
                    divZero  <= funct3[2] && (rs2_data == '0);
                    divOvf   <= ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM)) &&
                                (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
                    stepCnt  <= '0;
                end
            end else if (stepCnt == 6'(ITER_COUNT)) begin
                result    <= finalize(op, acc, negA, negB, divZero, divOvf);
                result_rd <= rdReg;
            end else begin
                stepCnt <= stepCnt + 6'd1;
                if (op[2])
                    acc <= divDiff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                         : {divDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                else
                    acc <= {mulSum, acc[XLEN-1:1]};
            end
        end
    end

endmodule
